mips_cpu_muldiv_unit: RTL

Multi-cycle multiply/divide unit with architectural HI/LO registers for the multicycle MIPS core. It sits directly downstream of the ALU control decoder and consumes its 5-bit `alucontrol` codes for MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI and MFLO. It runs multiply in one extra cycle and divide iteratively, and it raises `busy` so the control FSM can stall.

---
 rtl/mips_cpu_pkg.sv | 24 ++
 rtl/mips_cpu_div_iter.sv | 54 +++++
 rtl/mips_cpu_muldiv_unit.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/mips_cpu_pkg.sv
// Shared definitions for the multicycle MIPS core: ALU control codes and muldiv FSM states.
package mips_cpu_pkg;

    localparam logic [4:0] AluMultu = 5'b00111;
    localparam logic [4:0] AluMult  = 5'b01000;
    localparam logic [4:0] AluDiv   = 5'b01111;
    localparam logic [4:0] AluDivu  = 5'b10000;
    localparam logic [4:0] AluMthi  = 5'b10001;
    localparam logic [4:0] AluMtlo  = 5'b10010;
    localparam logic [4:0] AluMfhi  = 5'b11010;
    localparam logic [4:0] AluMflo  = 5'b11011;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StDiv,
        StFix
    } muldiv_state_e;

    function automatic logic [31:0] neg_if(input logic neg, input logic [31:0] val);
        return neg ? (~val + 32'd1) : val;
    endfunction

endpackage

// File: rtl/mips_cpu_div_iter.sv
// Unsigned restoring divider: one quotient bit per step, 32 steps after a load.
module mips_cpu_div_iter (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        step,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic [4:0]  count
);

    logic [31:0] rem_q;
    logic [31:0] quo_q;
    logic [31:0] dsr_q;
    logic [4:0]  cnt_q;
    logic [32:0] shifted;
    logic [33:0] diff;

    // Quotient register doubles as the dividend shifter: its MSB feeds the partial remainder.
    always_comb begin
        shifted = {rem_q, quo_q[31]};
        diff    = {1'b0, shifted} - {2'b00, dsr_q};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem_q <= 32'd0;
            quo_q <= 32'd0;
            dsr_q <= 32'd0;
            cnt_q <= 5'd0;
        end else if (load) begin
            rem_q <= 32'd0;
            quo_q <= dividend;
            dsr_q <= divisor;
            cnt_q <= 5'd0;
        end else if (step) begin
            if (!diff[33]) begin
                rem_q <= diff[31:0];
                quo_q <= {quo_q[30:0], 1'b1};
            end else begin
                rem_q <= shifted[31:0];
                quo_q <= {quo_q[30:0], 1'b0};
            end
            cnt_q <= cnt_q + 5'd1;
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign count     = cnt_q;

endmodule

// File: rtl/mips_cpu_muldiv_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers.
// Optional MULDIV_EARLY_TERM_EN skips the divide loop when |dividend| < |divisor|.
module mips_cpu_muldiv_unit
    import mips_cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [4:0]  alucontrol,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rdata
);

    muldiv_state_e state_q, state_d;
    logic        busy_q, done_q, done_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] op_a_q, op_b_q;
    logic        signed_q, qneg_q, rneg_q, dz_q, early_q;

    logic        latch_en, div_load, div_step;
    logic        sgn, a_neg, b_neg, early_hit;
    logic [31:0] a_mag, b_mag;
    logic [63:0] mul_a, mul_b, product;
    logic [31:0] quotient, remainder;
    logic [4:0]  count;

    always_comb begin
        sgn   = (alucontrol == AluDiv) || (alucontrol == AluMult);
        a_neg = sgn & a[31];
        b_neg = sgn & b[31];
        a_mag = neg_if(a_neg, a);
        b_mag = neg_if(b_neg, b);
`ifdef MULDIV_EARLY_TERM_EN
        early_hit = (b != 32'd0) && (a_mag < b_mag);
`else
        early_hit = 1'b0;
`endif
    end

    always_comb begin
        mul_a   = {{32{signed_q & op_a_q[31]}}, op_a_q};
        mul_b   = {{32{signed_q & op_b_q[31]}}, op_b_q};
        product = mul_a * mul_b;
    end

    mips_cpu_div_iter u_div_iter (
        .clk       (clk),
        .reset     (reset),
        .load      (div_load),
        .step      (div_step),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .quotient  (quotient),
        .remainder (remainder),
        .count     (count)
    );

    always_comb begin
        state_d  = state_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        latch_en = 1'b0;
        div_load = 1'b0;
        div_step = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    case (alucontrol)
                        AluMult, AluMultu: begin
                            latch_en = 1'b1;
                            state_d  = StMul;
                        end
                        AluDiv, AluDivu: begin
                            latch_en = 1'b1;
                            div_load = 1'b1;
                            state_d  = ((b == 32'd0) || early_hit) ? StFix : StDiv;
                        end
                        AluMthi: hi_d = a;
                        AluMtlo: lo_d = a;
                        default: ;
                    endcase
                end
            end
            StMul: begin
                hi_d    = product[63:32];
                lo_d    = product[31:0];
                done_d  = 1'b1;
                state_d = StIdle;
            end
            StDiv: begin
                div_step = 1'b1;
                if (count == 5'd31) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                // Divide-by-zero and early-terminated divides both return the raw dividend in HI.
                if (dz_q) begin
                    hi_d = op_a_q;
                    lo_d = 32'hFFFF_FFFF;
                end else if (early_q) begin
                    hi_d = op_a_q;
                    lo_d = 32'd0;
                end else begin
                    hi_d = neg_if(rneg_q, remainder);
                    lo_d = neg_if(qneg_q, quotient);
                end
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != StIdle);
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_a_q   <= 32'd0;
            op_b_q   <= 32'd0;
            signed_q <= 1'b0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
            early_q  <= 1'b0;
        end else if (latch_en) begin
            op_a_q   <= a;
            op_b_q   <= b;
            signed_q <= sgn;
            qneg_q   <= a_neg ^ b_neg;
            rneg_q   <= a_neg;
            dz_q     <= (b == 32'd0);
            early_q  <= early_hit;
        end
    end

    always_comb begin
        rdata = 32'd0;
        if (alucontrol == AluMfhi) begin
            rdata = hi_q;
        end else if (alucontrol == AluMflo) begin
            rdata = lo_q;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
